pfb_mux_2x: RTL and testbench
=============================

Name: pfb_mux_2x

Overview:
- Synthesis-side overlap-add stage for the 2x-oversampled polyphase filterbank. Inverse of the demux framing.
- Input: channelized frames of CHANNEL_COUNT complex samples, presented channel CHANNEL_COUNT-1 first, channel 0 last. Adjacent frames overlap by CHANNEL_COUNT/2 time positions.
- Output: serial complex stream of CHANNEL_COUNT/2 samples per frame, overlap-added from the previous and current frames.
- Sits between the synthesis filter/IFFT output and the serial sample sink.

Parameters:
CHANNEL_COUNT, 32, frame length; power of two, >= 4.
CHANNEL_INDEX_WIDTH, $clog2(CHANNEL_COUNT), width of the channel index.
DATA_WIDTH, 16, signed I/Q width, input and output.

Ports:
Clk  in  1  clock
Rst  in  1  synchronous reset, active-high
Input_valid  in  1  input sample strobe; no backpressure
Input_channel  in  CHANNEL_INDEX_WIDTH  channel index of the input sample
Input_i  in  DATA_WIDTH  signed I
Input_q  in  DATA_WIDTH  signed Q
Output_valid  out  1  output sample strobe
Output_first  out  1  marks the first output sample (k=0) of each frame
Output_i  out  DATA_WIDTH  signed I
Output_q  out  DATA_WIDTH  signed Q
Error_sequence  out  1  one-cycle pulse on a channel-order violation
Output_saturated  out  1  qualifies Output_valid; the sum clipped in I or Q

Behaviour:
- Clock and reset: single clock Clk; Rst is synchronous, active-high.
- Reset values: all outputs 0; state RUN; position p=0; prev_valid=0.
- Notation: H = CHANNEL_COUNT/2. Position of an input sample within its frame: p = CHANNEL_COUNT-1-Input_channel.
- Expected order: in RUN, every valid input must carry Input_channel == CHANNEL_COUNT-1-p. After p=CHANNEL_COUNT-1 accepted, p wraps to 0.
- First half (p < H):
  - Output y = x + (prev_valid ? buf[p] : 0), computed in DATA_WIDTH+1 bits, then reduced per the Optional Feature.
  - Output_first = (p==0).
- Second half (p >= H):
  - x written to buf[p-H] (H-entry complex buffer); no output.
  - On accepting p=CHANNEL_COUNT-1, prev_valid set to 1.
- Latency: Output_valid asserts exactly 2 cycles after the qualifying Input_valid. Stage 1 = add; stage 2 = reduce/register. One output per first-half input; throughput 1 sample/cycle.
- Steady state: H outputs per frame, i.e. serial sample rate = frame rate x H.
- Sequence violation in RUN:
  - Sample discarded.
  - Error_sequence pulses with the same 2-cycle latency.
  - prev_valid cleared; state -> RESYNC.
- RESYNC:
  - All inputs discarded; no further Error_sequence pulses.
  - An input with Input_channel == CHANNEL_COUNT-1 is accepted as p=0 of a new frame (processed normally) and returns the state to RUN.
- Simultaneous events: a violating sample that carries channel CHANNEL_COUNT-1 in RUN still flags an error, then immediately resyncs on it as p=0 (no discard for that case).
- Reset mid-frame: pipeline flushed; outputs 0 next cycle; partial frame lost; prev_valid=0. The first frame after reset outputs its first half unmodified.
- Gaps between valids are arbitrary and do not affect state.

Optional Feature:
- Macro: PFB_MUX_2X_SATURATE_EN.
- Defined: the (DATA_WIDTH+1)-bit sum saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] per component. Output_saturated=1 on any clip.
- Undefined: the sum wraps (low DATA_WIDTH bits kept). Output_saturated is constant 0. Saves the compare logic.

Decomposition:
- dsp_pkg gets:
  - a pfb_mux_state_t enum {RUN, RESYNC};
  - a complex-sample struct typedef parameterized by width via localparam usage in the module;
  - a sat_add helper function.
- Sub-module: pfb_mux_2x_overlap_buf, the H-entry dual-port I/Q storage (write p>=H, read p<H), inferable as distributed RAM.

Test Plan:
- Reset, then 4 ordered frames (channels 31..0) with x(frame f, p) = 100*f + p for I and -(100*f + p) for Q:
  - frame 0 outputs I = 0..15;
  - frame f>=1 outputs I = (100f+k) + (100(f-1)+16+k);
  - 16 outputs per frame, Output_first on k=0, 2-cycle latency.
- Random gaps of 0-7 cycles between valids on the same stimulus -> identical output sequence.
- Frame 1 skips channel 20 (p=11):
  - Error_sequence pulses once;
  - inputs are dropped until the next channel 31;
  - the next frame outputs its first half unmodified, then normal overlap resumes.
- Both halves at +32767 (saturate build):
  - outputs 32767 with Output_saturated=1;
  - in the wrap build: -2 and Output_saturated=0;
  - at -32768 + -32768: saturate build gives -32768; wrap build gives 0.
- Rst asserted at p=20 of frame 2:
  - all outputs 0 the next cycle;
  - the following frame passes its first half unmodified.
- 20 random frames of 16-bit random I/Q checked against a golden overlap-add model -> zero mismatches, no Error_sequence.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared types and arithmetic helpers for the polyphase filterbank datapath.
package dsp_pkg;

    typedef enum logic {
        RUN,
        RESYNC
    } pfb_mux_state_t;

    // Widest sum sat_add can clip; callers sign-extend into it and keep the low bits.
    localparam int unsigned SAT_MAX_W = 32;

    typedef struct packed {
        logic                        clipped;
        logic signed [SAT_MAX_W-1:0] value;
    } sat_result_t;

    function automatic sat_result_t sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W-1:0] sum;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_result_t                 r;
        sum       = a + b;
        hi        = (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
        lo        = ~hi;
        r.clipped = 1'b1;
        if (sum > hi) begin
            r.value = hi;
        end else if (sum < lo) begin
            r.value = lo;
        end else begin
            r.value   = sum;
            r.clipped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pfb_mux_2x_overlap_buf.sv
// Half-frame I/Q overlap store: second-half samples are written, the next
// frame's first half reads them asynchronously (maps to distributed RAM).
module pfb_mux_2x_overlap_buf #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         wr_en_i,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
    input  logic signed [DATA_WIDTH-1:0] wr_re_i,
    input  logic signed [DATA_WIDTH-1:0] wr_im_i,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
    output logic signed [DATA_WIDTH-1:0] rd_re_o,
    output logic signed [DATA_WIDTH-1:0] rd_im_o
);

    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= {wr_re_i, wr_im_i};
        end
    end

    assign {rd_re_o, rd_im_o} = mem_q[rd_addr_i];

endmodule

// File: rtl/pfb_mux_2x.sv
// 2x-oversampled PFB synthesis overlap-add stage (frame -> serial stream).
// Define PFB_MUX_2X_SATURATE_EN to saturate the sum instead of wrapping.
module pfb_mux_2x
    import dsp_pkg::*;
#(
    parameter int unsigned CHANNEL_COUNT       = 32,
    parameter int unsigned CHANNEL_INDEX_WIDTH = $clog2(CHANNEL_COUNT),
    parameter int unsigned DATA_WIDTH          = 16
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Input_valid,
    input  logic [CHANNEL_INDEX_WIDTH-1:0] Input_channel,
    input  logic signed [DATA_WIDTH-1:0]   Input_i,
    input  logic signed [DATA_WIDTH-1:0]   Input_q,
    output logic                           Output_valid,
    output logic                           Output_first,
    output logic signed [DATA_WIDTH-1:0]   Output_i,
    output logic signed [DATA_WIDTH-1:0]   Output_q,
    output logic                           Error_sequence,
    output logic                           Output_saturated
);

    localparam int unsigned H  = CHANNEL_COUNT / 2;
    localparam int unsigned AW = CHANNEL_INDEX_WIDTH - 1;
    localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_CH = CHANNEL_INDEX_WIDTH'(CHANNEL_COUNT - 1);
`ifdef PFB_MUX_2X_SATURATE_EN
    localparam int unsigned SUM_W = DATA_WIDTH + 1;
`else
    localparam int unsigned SUM_W = DATA_WIDTH;  // wrapping drops the carry, so add at output width
`endif

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] i;
        logic signed [DATA_WIDTH-1:0] q;
    } cplx_t;

    typedef struct packed {
        logic signed [SUM_W-1:0] i;
        logic signed [SUM_W-1:0] q;
    } sum_t;

    pfb_mux_state_t                 state_q, state_d;
    logic [CHANNEL_INDEX_WIDTH-1:0] p_q, p_d, pos;
    logic                           prev_valid_q, prev_valid_d;
    logic                           accept, use_prev, seq_err;
    logic                           out1_d, out1_q, first1_d, first1_q, err1_q;
    cplx_t                          in_s, rd_s, add_s, red_s, out_s_q;
    sum_t                           sum_d, sum1_q;
    logic signed [DATA_WIDTH-1:0]   rd_re, rd_im;
    logic                           red_clip;
    logic                           out_valid_q, out_first_q, err_q, sat_q;

    assign in_s = {Input_i, Input_q};
    assign rd_s = {rd_re, rd_im};

    pfb_mux_2x_overlap_buf #(
        .DEPTH      (H),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i     (Clk),
        .wr_en_i   (accept & pos[CHANNEL_INDEX_WIDTH-1]),
        .wr_addr_i (pos[AW-1:0]),
        .wr_re_i   (Input_i),
        .wr_im_i   (Input_q),
        .rd_addr_i (pos[AW-1:0]),
        .rd_re_o   (rd_re),
        .rd_im_o   (rd_im)
    );

    // A violating sample on the top channel restarts the frame on itself.
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        prev_valid_d = prev_valid_q;
        accept       = 1'b0;
        pos          = p_q;
        use_prev     = prev_valid_q;
        seq_err      = 1'b0;
        if (Input_valid) begin
            case (state_q)
                RUN: begin
                    if (Input_channel == LAST_CH - p_q) begin
                        accept = 1'b1;
                    end else begin
                        seq_err      = 1'b1;
                        use_prev     = 1'b0;
                        prev_valid_d = 1'b0;
                        if (Input_channel == LAST_CH) begin
                            accept = 1'b1;
                            pos    = '0;
                        end else begin
                            state_d = RESYNC;
                        end
                    end
                end
                RESYNC: begin
                    if (Input_channel == LAST_CH) begin
                        accept  = 1'b1;
                        pos     = '0;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        if (accept) begin
            p_d = pos + 1'b1;
            if (pos == LAST_CH) begin
                prev_valid_d = 1'b1;
            end
        end
        out1_d   = accept & ~pos[CHANNEL_INDEX_WIDTH-1];
        first1_d = out1_d & (pos == '0);
        add_s    = use_prev ? rd_s : '0;
        sum_d.i  = SUM_W'(in_s.i) + SUM_W'(add_s.i);
        sum_d.q  = SUM_W'(in_s.q) + SUM_W'(add_s.q);
    end

`ifdef PFB_MUX_2X_SATURATE_EN
    sat_result_t sat_re, sat_im;
    logic        unused_sat_hi;
    always_comb begin
        sat_re = sat_add(SAT_MAX_W'(sum1_q.i), '0, DATA_WIDTH);
        sat_im = sat_add(SAT_MAX_W'(sum1_q.q), '0, DATA_WIDTH);
    end
    assign red_s         = {sat_re.value[DATA_WIDTH-1:0], sat_im.value[DATA_WIDTH-1:0]};
    assign red_clip      = sat_re.clipped | sat_im.clipped;
    assign unused_sat_hi = ^{sat_re.value[SAT_MAX_W-1:DATA_WIDTH], sat_im.value[SAT_MAX_W-1:DATA_WIDTH]};
`else
    assign red_s    = sum1_q;
    assign red_clip = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= RUN;
            p_q          <= '0;
            prev_valid_q <= 1'b0;
            out1_q       <= 1'b0;
            first1_q     <= 1'b0;
            err1_q       <= 1'b0;
            sum1_q       <= '0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            err_q        <= 1'b0;
            sat_q        <= 1'b0;
            out_s_q      <= '0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            prev_valid_q <= prev_valid_d;
            out1_q       <= out1_d;
            first1_q     <= first1_d;
            err1_q       <= seq_err;
            sum1_q       <= sum_d;
            out_valid_q  <= out1_q;
            out_first_q  <= first1_q;
            err_q        <= err1_q;
            sat_q        <= out1_q & red_clip;
            if (out1_q) begin
                out_s_q <= red_s;
            end
        end
    end

    assign Output_valid     = out_valid_q;
    assign Output_first     = out_first_q;
    assign Output_i         = out_s_q.i;
    assign Output_q         = out_s_q.q;
    assign Error_sequence   = err_q;
    assign Output_saturated = sat_q;

endmodule

// File: tb/tb_pfb_mux_2x.sv
// Randomized bench for pfb_mux_2x against a frame-level overlap-add model.
module tb_pfb_mux_2x;

    localparam int CC   = 32;
    localparam int CIW  = 5;
    localparam int DW   = 16;
    localparam int H    = CC / 2;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));
    localparam int SPAN = 1 << DW;

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b1;
    logic                 Input_valid = 1'b0;
    logic [CIW-1:0]       Input_channel = '0;
    logic signed [DW-1:0] Input_i = '0;
    logic signed [DW-1:0] Input_q = '0;
    logic                 Output_valid, Output_first, Error_sequence, Output_saturated;
    logic signed [DW-1:0] Output_i, Output_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_seen = 0;
    bit mon_en   = 1'b0;

    pfb_mux_2x #(
        .CHANNEL_COUNT (CC),
        .DATA_WIDTH    (DW)
    ) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Input_valid      (Input_valid),
        .Input_channel    (Input_channel),
        .Input_i          (Input_i),
        .Input_q          (Input_q),
        .Output_valid     (Output_valid),
        .Output_first     (Output_first),
        .Output_i         (Output_i),
        .Output_q         (Output_q),
        .Error_sequence   (Error_sequence),
        .Output_saturated (Output_saturated)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: whole-frame view, one entry per expected output.
    typedef struct {
        int due;
        int i;
        int q;
        bit first;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    bit   m_resync;
    bit   m_have_prev;
    int   m_pos;
    int   m_prev_i[H];
    int   m_prev_q[H];

    function automatic void reduce(input int s, output int r, output bit sat);
`ifdef PFB_MUX_2X_SATURATE_EN
        sat = 1'b1;
        if (s > MAXV) r = MAXV;
        else if (s < MINV) r = MINV;
        else begin
            r   = s;
            sat = 1'b0;
        end
`else
        r   = ((s - MINV) % SPAN + SPAN) % SPAN + MINV;
        sat = 1'b0;
`endif
    endfunction

    task automatic m_accept(input int pp, input int xi, input int xq);
        exp_t e;
        int   ri, rq;
        bit   si, sq;
        if (pp < H) begin
            reduce(xi + (m_have_prev ? m_prev_i[pp] : 0), ri, si);
            reduce(xq + (m_have_prev ? m_prev_q[pp] : 0), rq, sq);
            e.due   = cyc + 2;
            e.i     = ri;
            e.q     = rq;
            e.first = (pp == 0);
            e.sat   = si | sq;
            exp_q.push_back(e);
        end else begin
            m_prev_i[pp-H] = xi;
            m_prev_q[pp-H] = xq;
        end
        if (pp == CC - 1) m_have_prev = 1'b1;
        m_pos = (pp + 1) % CC;
    endtask

    task automatic model_in(input int ch, input int xi, input int xq);
        if (!m_resync) begin
            if (ch == CC - 1 - m_pos) begin
                m_accept(m_pos, xi, xq);
            end else begin
                err_q.push_back(cyc + 2);
                m_have_prev = 1'b0;
                if (ch == CC - 1) m_accept(0, xi, xq);
                else m_resync = 1'b1;
            end
        end else if (ch == CC - 1) begin
            m_resync = 1'b0;
            m_accept(0, xi, xq);
        end
    endtask

    always @(negedge Clk) begin : mon
        bit   ev;
        bit   eerr;
        exp_t e;
        if (mon_en) begin
            ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("out_valid", Output_valid, ev);
            if (ev) begin
                e = exp_q.pop_front();
                chk("out_i", Output_i, e.i);
                chk("out_q", Output_q, e.q);
                chk("out_first", Output_first, e.first);
                chk("out_sat", Output_saturated, e.sat);
            end else begin
                chk("idle_sat", Output_saturated, 0);
            end
            eerr = (err_q.size() > 0) && (err_q[0] == cyc);
            chk("err_seq", Error_sequence, eerr);
            if (eerr) void'(err_q.pop_front());
            if (Error_sequence) err_seen++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input int ch, input int xi, input int xq, input int gap);
        Input_valid   = 1'b1;
        Input_channel = CIW'(ch);
        Input_i       = DW'(xi);
        Input_q       = DW'(xq);
        model_in(ch, xi, xq);
        tick();
        Input_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input int f, input int gapmax, input int skip_p, input int stop_p);
        for (int p = 0; p < stop_p; p++) begin
            if (p != skip_p)
                send(CC - 1 - p, 100 * f + p, -(100 * f + p), (gapmax > 0) ? int'($urandom_range(gapmax)) : 0);
        end
    endtask

    task automatic do_reset();
        Rst         = 1'b1;
        Input_valid = 1'b0;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
        while (err_q.size() > 0 && err_q[err_q.size()-1] > cyc) void'(err_q.pop_back());
        m_resync    = 1'b0;
        m_have_prev = 1'b0;
        m_pos       = 0;
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_valid", Output_valid, 0);
        chk("rst_first", Output_first, 0);
        chk("rst_i", Output_i, 0);
        chk("rst_q", Output_q, 0);
        chk("rst_err", Error_sequence, 0);
        chk("rst_sat", Output_saturated, 0);
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        int e0;
        tick();
        do_reset();
        mon_en = 1'b1;

        for (int f = 0; f < 4; f++) send_frame(f, 0, -1, CC);
        repeat (4) tick();

        do_reset();
        for (int f = 0; f < 4; f++) send_frame(f, 7, -1, CC);
        repeat (4) tick();

        do_reset();
        e0 = err_seen;
        send_frame(0, 0, -1, CC);
        send_frame(1, 0, 11, CC);
        send_frame(2, 0, -1, CC);
        send_frame(3, 0, -1, CC);
        repeat (4) tick();
        chk("err_once_skip", err_seen - e0, 1);
        e0 = err_seen;
        send_frame(4, 1, -1, 6);
        send_frame(5, 0, -1, CC);
        send_frame(6, 0, -1, CC);
        repeat (4) tick();
        chk("err_once_restart", err_seen - e0, 1);

        do_reset();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < CC; p++) send(CC - 1 - p, MAXV, MINV, 0);
        repeat (4) tick();

        do_reset();
        send_frame(0, 0, -1, CC);
        send_frame(1, 0, -1, CC);
        send_frame(2, 0, -1, 20);
        do_reset();
        send_frame(3, 0, -1, CC);

        e0 = err_seen;
        for (int f = 0; f < 20; f++)
            for (int p = 0; p < CC; p++)
                send(CC - 1 - p, int'($urandom_range(SPAN - 1)) + MINV,
                     int'($urandom_range(SPAN - 1)) + MINV, int'($urandom_range(2)));
        repeat (4) tick();
        chk("no_err_random", err_seen - e0, 0);
        chk("drain_out", exp_q.size(), 0);
        chk("drain_err", err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
